// File: rtl/btn_cond.sv
// Pushbutton conditioner: synchronizes and debounces write/read buttons
// and turns each qualified press into a single FIFO strobe.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       btn_cond_port_clk,
  input  logic       btn_cond_port_rst,
  input  logic       btn_cond_port_w_raw,
  input  logic       btn_cond_port_r_raw,
  input  logic [3:0] btn_cond_port_data_raw,
  input  logic       btn_cond_port_full,
  input  logic       btn_cond_port_empty,
  output logic       btn_cond_port_w,
  output logic       btn_cond_port_r,
  output logic [3:0] btn_cond_port_data,
  output logic       btn_cond_port_drop
);

  localparam int CLOG = $clog2(DEBOUNCE_CYCLES);
  localparam int CW = (CLOG > 1) ? CLOG : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HELD,
    S_REL
  } state_t;

  // index 0 is the write button, index 1 the read button
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [3:0]    r_dsync1;
  logic [3:0]    r_dsync2;
  state_t        r_st [2];
  state_t        w_st_nxt [2];
  logic [CW-1:0] r_cnt [2];
  logic [CW-1:0] w_cnt_nxt [2];
  logic [1:0]    w_qual;
  logic          r_w;
  logic          r_r;
  logic          r_drop;
  logic [3:0]    r_data;

  always_ff @(posedge btn_cond_port_clk or negedge btn_cond_port_rst) begin
    if (!btn_cond_port_rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_dsync1 <= '0;
      r_dsync2 <= '0;
    end else begin
      r_sync1  <= {btn_cond_port_r_raw, btn_cond_port_w_raw};
      r_sync2  <= r_sync1;
      r_dsync1 <= btn_cond_port_data_raw;
      r_dsync2 <= r_dsync1;
    end
  end

  always_ff @(posedge btn_cond_port_clk or negedge btn_cond_port_rst) begin
    if (!btn_cond_port_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= S_IDLE;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]  <= w_st_nxt[i];
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_st_nxt[i]  = r_st[i];
      w_cnt_nxt[i] = r_cnt[i];
      w_qual[i]    = 1'b0;
      unique case (r_st[i])
        S_IDLE: begin
          if (r_sync2[i]) begin
            w_st_nxt[i]  = S_ARM;
            w_cnt_nxt[i] = '0;
          end
        end
        S_ARM: begin
          if (!r_sync2[i]) begin
            w_st_nxt[i] = S_IDLE;
          end else if (r_cnt[i] == LAST) begin
            w_st_nxt[i] = S_HELD;
            w_qual[i]   = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CW'(1);
          end
        end
        S_HELD: begin
          if (!r_sync2[i]) begin
            w_st_nxt[i]  = S_REL;
            w_cnt_nxt[i] = '0;
          end
        end
        S_REL: begin
          if (r_sync2[i]) begin
            w_st_nxt[i] = S_HELD;
          end else if (r_cnt[i] == LAST) begin
            w_st_nxt[i] = S_IDLE;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CW'(1);
          end
        end
        default: begin
          w_st_nxt[i]  = S_IDLE;
          w_cnt_nxt[i] = '0;
        end
      endcase
    end
  end

  // a press blocked by full/empty is reported on drop instead
  always_ff @(posedge btn_cond_port_clk or negedge btn_cond_port_rst) begin
    if (!btn_cond_port_rst) begin
      r_w    <= 1'b0;
      r_r    <= 1'b0;
      r_drop <= 1'b0;
      r_data <= '0;
    end else begin
      r_w    <= w_qual[0] & ~btn_cond_port_full;
      r_r    <= w_qual[1] & ~btn_cond_port_empty;
      r_drop <= (w_qual[0] & btn_cond_port_full) |
                (w_qual[1] & btn_cond_port_empty);
      if (w_qual[0] && !btn_cond_port_full) begin
        r_data <= r_dsync2;
      end
    end
  end

  assign btn_cond_port_w    = r_w;
  assign btn_cond_port_r    = r_r;
  assign btn_cond_port_drop = r_drop;
  assign btn_cond_port_data = r_data;

endmodule

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: directed scenarios plus random button activity
// checked against a run-length reference model.
module tb_btn_cond;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_raw = 1'b0;
  logic       r_raw = 1'b0;
  logic [3:0] d_raw = '0;
  logic       full = 1'b0;
  logic       empty = 1'b0;
  logic       w;
  logic       r;
  logic [3:0] data;
  logic       drop;

  always #5 clk = ~clk;

  btn_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .btn_cond_port_clk      (clk),
    .btn_cond_port_rst      (rst_n),
    .btn_cond_port_w_raw    (w_raw),
    .btn_cond_port_r_raw    (r_raw),
    .btn_cond_port_data_raw (d_raw),
    .btn_cond_port_full     (full),
    .btn_cond_port_empty    (empty),
    .btn_cond_port_w        (w),
    .btn_cond_port_r        (r),
    .btn_cond_port_data     (data),
    .btn_cond_port_drop     (drop)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit       w;
    bit       r;
    bit [3:0] d;
  } samp_t;

  samp_t    hist[$];
  int       hi_run[2];
  int       lo_run[2];
  bit       pressed[2];
  bit       e_w, e_r, e_drop;
  bit [3:0] e_data;

  int ecount, wc, rc, dc, bothc, w_edge;

  task automatic model_reset();
    samp_t z;
    z = '{w: 1'b0, r: 1'b0, d: 4'h0};
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    for (int b = 0; b < 2; b++) begin
      hi_run[b]  = 0;
      lo_run[b]  = 0;
      pressed[b] = 1'b0;
    end
    e_w = 0; e_r = 0; e_drop = 0; e_data = '0;
  endtask

  // a press counts after N+1 consecutive high samples while released;
  // the button is released again after N+1 consecutive low samples
  task automatic model_edge();
    samp_t s;
    bit in[2];
    bit q[2];
    s = hist.pop_front();
    hist.push_back('{w: w_raw, r: r_raw, d: d_raw});
    in[0] = s.w;
    in[1] = s.r;
    for (int b = 0; b < 2; b++) begin
      q[b] = 1'b0;
      if (in[b]) begin
        lo_run[b] = 0;
        hi_run[b]++;
        if (!pressed[b] && hi_run[b] == N + 1) begin
          q[b] = 1'b1;
          pressed[b] = 1'b1;
        end
      end else begin
        hi_run[b] = 0;
        lo_run[b]++;
        if (pressed[b] && lo_run[b] == N + 1) pressed[b] = 1'b0;
      end
    end
    e_w    = q[0] & ~full;
    e_r    = q[1] & ~empty;
    e_drop = (q[0] & full) | (q[1] & empty);
    if (e_w) e_data = s.d;
  endtask

  task automatic clr_counts();
    ecount = 0; wc = 0; rc = 0; dc = 0; bothc = 0; w_edge = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    ecount++;
    if (w) wc++;
    if (r) rc++;
    if (drop) dc++;
    if (w && r) bothc++;
    if (w && w_edge < 0) w_edge = ecount;
    check("w", w, e_w);
    check("r", r, e_r);
    check("drop", drop, e_drop);
    check("data", data, e_data);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_rst(int cyc);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_w", w, 0);
    check("rst_async_r", r, 0);
    check("rst_async_drop", drop, 0);
    check("rst_async_data", data, 0);
    ticks(cyc);
    rst_n = 1'b1;
  endtask

  initial begin
    int hold[2];
    model_reset();
    clr_counts();
    ticks(3);
    check("reset_w", w, 0);
    check("reset_data", data, 0);
    rst_n = 1'b1;
    ticks(3);

    // clean press
    d_raw = 4'd4;
    w_raw = 1'b1;
    clr_counts();
    ticks(20);
    check("clean_edge", w_edge, 7);
    check("clean_cnt", wc, 1);
    check("clean_data", data, 4);
    check("clean_drop", dc, 0);
    w_raw = 1'b0;
    ticks(20);
    check("clean_rel_cnt", wc, 1);

    // bounce
    clr_counts();
    d_raw = 4'd9;
    w_raw = 1; ticks(2);
    w_raw = 0; ticks(1);
    w_raw = 1; ticks(2);
    w_raw = 0; ticks(15);
    check("bounce_cnt", wc, 0);
    check("bounce_drop", dc, 0);

    // full
    clr_counts();
    full = 1'b1;
    w_raw = 1'b1;
    ticks(10);
    check("full_w", wc, 0);
    check("full_drop", dc, 1);
    check("full_data", data, 4);
    w_raw = 1'b0;
    ticks(12);
    full = 1'b0;

    // simultaneous
    clr_counts();
    w_raw = 1; r_raw = 1;
    ticks(10);
    check("simul_both", bothc, 1);
    check("simul_w", wc, 1);
    check("simul_r", rc, 1);
    w_raw = 0; r_raw = 0;
    ticks(12);

    // reset mid-ARM
    clr_counts();
    w_raw = 1'b1;
    ticks(3);
    async_rst(2);
    clr_counts();
    ticks(12);
    check("rstarm_edge", w_edge, 7);
    check("rstarm_cnt", wc, 1);
    w_raw = 1'b0;
    ticks(12);

    // long hold with glitch
    clr_counts();
    w_raw = 1'b1;
    ticks(1000);
    w_raw = 1'b0;
    ticks(2);
    w_raw = 1'b1;
    ticks(20);
    check("long_cnt", wc, 1);
    w_raw = 1'b0;
    ticks(12);

    // random activity
    hold[0] = 0;
    hold[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (hold[b] == 0) begin
          hold[b] = $urandom_range(1, 12);
          if (b == 0) w_raw = $urandom_range(0, 1);
          else r_raw = $urandom_range(0, 1);
        end
        hold[b]--;
      end
      d_raw = 4'($urandom);
      if ($urandom_range(0, 7) == 0) full = ~full;
      if ($urandom_range(0, 7) == 0) empty = ~empty;
      if ($urandom_range(0, 499) == 0) async_rst($urandom_range(1, 2));
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
